// File: rtl/chinx_clkgen.sv
// chinx_clkgen: multi-channel programmable clock/strobe divider with shadowed runtime config.
// Optional define CLKGEN_SYNC_EN adds the sync_n phase-align input.
module chinx_clkgen #(
  parameter int CHANNELS     = 2,
  parameter int CNT_W        = 16,
  parameter int DEFAULT_DIV  = 100,
  parameter int DEFAULT_HIGH = 50,
  localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
`ifdef CLKGEN_SYNC_EN
  input  logic                sync_n,
`endif
  input  logic [CHANNELS-1:0] en,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [CNT_W-1:0]    cfg_div,
  input  logic [CNT_W-1:0]    cfg_high,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] busy
);

  logic [CHANNELS-1:0] pend;
  logic [CHANNELS-1:0] acc;

  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] div);
    return (div < CNT_W'(2)) ? CNT_W'(2) : div;
  endfunction

  function automatic logic [CNT_W-1:0] clamp_high(input logic [CNT_W-1:0] high,
                                                  input logic [CNT_W-1:0] d);
    return (high > d) ? d : high;
  endfunction

  // Channel numbers outside the populated range never match, so they read as not ready.
  always_comb begin
    cfg_ready = 1'b0;
    acc       = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready = ~pend[i];
        acc[i]    = cfg_valid & ~pend[i];
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [CNT_W-1:0] cnt_p0;
    logic [CNT_W-1:0] act_div;
    logic [CNT_W-1:0] act_high;
    logic [CNT_W-1:0] shd_div;
    logic [CNT_W-1:0] shd_high;
    logic [CNT_W-1:0] d_act;
    logic [CNT_W-1:0] h_act;
    logic [CNT_W-1:0] d_shd;
    logic [CNT_W-1:0] h_shd;
    logic             pend_q;
    logic             clk_out_p1;
    logic             tick_p1;
    logic             boundary;
    logic             sync_hit;
    logic             apply;

    assign d_act    = clamp_div(act_div);
    assign h_act    = clamp_high(act_high, d_act);
    assign d_shd    = clamp_div(shd_div);
    assign h_shd    = clamp_high(shd_high, d_shd);
    assign boundary = en[g] & (cnt_p0 == d_act - CNT_W'(1));
`ifdef CLKGEN_SYNC_EN
    assign sync_hit = ~sync_n & en[g];
`else
    assign sync_hit = 1'b0;
`endif
    assign apply    = pend_q & (sync_hit | ~en[g] | boundary);

    // Shadow/active config; accept and apply are exclusive because accept needs a free slot.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        act_div  <= CNT_W'(DEFAULT_DIV);
        act_high <= CNT_W'(DEFAULT_HIGH);
        shd_div  <= CNT_W'(DEFAULT_DIV);
        shd_high <= CNT_W'(DEFAULT_HIGH);
        pend_q   <= 1'b0;
      end else if (acc[g]) begin
        shd_div  <= cfg_div;
        shd_high <= cfg_high;
        pend_q   <= 1'b1;
      end else if (apply) begin
        act_div  <= shd_div;
        act_high <= shd_high;
        pend_q   <= 1'b0;
      end
    end

    // p0 -> p1: outputs register the count of the current cycle; a sync consumes count 0 now.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_p0     <= '0;
        tick_p1    <= 1'b0;
        clk_out_p1 <= 1'b0;
      end else if (sync_hit) begin
        cnt_p0     <= CNT_W'(1);
        tick_p1    <= 1'b1;
        clk_out_p1 <= pend_q ? (h_shd == d_shd) : (h_act == d_act);
      end else if (en[g]) begin
        cnt_p0     <= boundary ? '0 : cnt_p0 + CNT_W'(1);
        tick_p1    <= (cnt_p0 == '0);
        clk_out_p1 <= (cnt_p0 >= d_act - h_act);
      end else begin
        cnt_p0     <= '0;
        tick_p1    <= 1'b0;
        clk_out_p1 <= 1'b0;
      end
    end

    assign pend[g]    = pend_q;
    assign busy[g]    = pend_q;
    assign clk_out[g] = clk_out_p1;
    assign tick[g]    = tick_p1;
  end

endmodule

// File: tb/tb_chinx_clkgen.sv
// tb_chinx_clkgen: directed and randomized checks of chinx_clkgen against a
// period-position reference model (clamped period/high, position in period).
`timescale 1ns/1ps
module tb_chinx_clkgen;
  localparam int CH    = 2;
  localparam int CW    = 16;
  localparam int DDIV  = 100;
  localparam int DHIGH = 50;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
`ifdef CLKGEN_SYNC_EN
  logic          sync_n = 1'b1;
`endif
  logic [CH-1:0] en = '0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [0:0]    cfg_ch = '0;
  logic [CW-1:0] cfg_div = '0;
  logic [CW-1:0] cfg_high = '0;
  logic [CH-1:0] clk_out;
  logic [CH-1:0] tick;
  logic [CH-1:0] busy;

  int checks = 0;
  int errors = 0;

  int m_d[CH];
  int m_h[CH];
  int m_sd[CH];
  int m_sh[CH];
  int m_pos[CH];
  bit m_pend[CH];
  logic [CH-1:0] e_clk;
  logic [CH-1:0] e_tick;
  logic [CH-1:0] e_busy;

  always #5 clk = ~clk;

  chinx_clkgen #(
    .CHANNELS(CH), .CNT_W(CW), .DEFAULT_DIV(DDIV), .DEFAULT_HIGH(DHIGH)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef CLKGEN_SYNC_EN
    .sync_n(sync_n),
`endif
    .en(en),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch),
    .cfg_div(cfg_div),
    .cfg_high(cfg_high),
    .clk_out(clk_out),
    .tick(tick),
    .busy(busy)
  );

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_d[c] = DDIV; m_h[c] = DHIGH; m_sd[c] = DDIV; m_sh[c] = DHIGH;
      m_pos[c] = 0; m_pend[c] = 1'b0;
    end
    e_clk = '0; e_tick = '0; e_busy = '0;
  endtask

  task automatic model_apply(input int c);
    if (m_pend[c]) begin
      m_d[c] = m_sd[c]; m_h[c] = m_sh[c]; m_pend[c] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit take;
    bit sy;
    int wc;
    if (!rst) begin
      model_reset();
    end else begin
      wc = int'(cfg_ch);
      take = cfg_valid && (wc < CH) && !m_pend[wc];
      for (int c = 0; c < CH; c++) begin
        sy = 1'b0;
`ifdef CLKGEN_SYNC_EN
        sy = !sync_n && en[c];
`endif
        if (sy) begin
          model_apply(c);
          e_tick[c] = 1'b1;
          e_clk[c]  = (m_h[c] == m_d[c]);
          m_pos[c]  = 1;
        end else if (en[c]) begin
          e_tick[c] = (m_pos[c] == 0);
          e_clk[c]  = (m_pos[c] >= m_d[c] - m_h[c]);
          m_pos[c]  = m_pos[c] + 1;
          if (m_pos[c] == m_d[c]) begin
            m_pos[c] = 0;
            model_apply(c);
          end
        end else begin
          e_tick[c] = 1'b0;
          e_clk[c]  = 1'b0;
          m_pos[c]  = 0;
          model_apply(c);
        end
      end
      if (take) begin
        m_sd[wc]   = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
        m_sh[wc]   = (int'(cfg_high) > m_sd[wc]) ? m_sd[wc] : int'(cfg_high);
        m_pend[wc] = 1'b1;
      end
      for (int c = 0; c < CH; c++) e_busy[c] = m_pend[c];
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic write_and_apply(input int ch, input int div, input int high, output bit ok);
    int n;
    n = 0;
    cfg_valid = 1'b1; cfg_ch = 1'(ch); cfg_div = CW'(div); cfg_high = CW'(high);
    #1;
    while (cfg_ready !== 1'b1 && n < 400) begin cycle(); n++; end
    cycle();
    cfg_valid = 1'b0;
    while (busy[ch] !== 1'b0 && n < 800) begin cycle(); n++; end
    ok = (busy[ch] === 1'b0);
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    model_reset();
    repeat (3) cycle();
    checks++;
    if ({clk_out, tick, busy} !== 6'b0) begin
      errors++; $display("FAIL reset_outputs got %b want 000000", {clk_out, tick, busy});
    end
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++; $display("FAIL reset_cfg_ready got %b want 1", cfg_ready);
    end
    rst = 1'b1;
  endtask

  task automatic test_default_wave();
    int hi;
    int tk;
    int early;
    hi = 0; tk = 0; early = 0;
    en = 2'b01;
    for (int i = 0; i < 200; i++) begin
      cycle();
      checks++;
      if ({clk_out, tick, busy} !== {e_clk, e_tick, e_busy}) begin
        errors++;
        $display("FAIL default_wave cyc=%0d got clk_out=%b tick=%b busy=%b want %b %b %b",
                 i, clk_out, tick, busy, e_clk, e_tick, e_busy);
      end
      if (i == 0) begin
        checks++;
        if (tick[0] !== 1'b1) begin
          errors++; $display("FAIL default_first_tick got %b want 1", tick[0]);
        end
      end
      if (clk_out[0] === 1'b1) hi++;
      if (clk_out[0] === 1'b1 && i < 50) early++;
      if (tick[0] === 1'b1) tk++;
    end
    checks++;
    if (hi != 100) begin errors++; $display("FAIL default_high_count got %0d want 100", hi); end
    checks++;
    if (early != 0) begin errors++; $display("FAIL default_low_phase got %0d high cycles want 0", early); end
    checks++;
    if (tk != 2) begin errors++; $display("FAIL default_tick_count got %0d want 2", tk); end
  endtask

  task automatic test_cfg_busy();
    int n;
    en = 2'b11;
    for (int i = 0; i < 20; i++) begin
      cycle();
      checks++;
      if ({clk_out, tick, busy} !== {e_clk, e_tick, e_busy}) begin
        errors++; $display("FAIL cfg_prerun cyc=%0d got %b want %b", i, {clk_out, tick, busy}, {e_clk, e_tick, e_busy});
      end
    end
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_div = CW'(4); cfg_high = CW'(1);
    #1;
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL cfg_ready_idle got %b want 1", cfg_ready); end
    cycle();
    checks++;
    if (busy[1] !== 1'b1) begin errors++; $display("FAIL busy_set got %b want 1", busy[1]); end
    cfg_div = CW'(8); cfg_high = CW'(4);
    #1;
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL cfg_ready_busy got %b want 0", cfg_ready); end
    cycle();
    cfg_valid = 1'b0;
    for (n = 0; n < 300; n++) begin
      checks++;
      if ({clk_out, tick, busy} !== {e_clk, e_tick, e_busy}) begin
        errors++; $display("FAIL cfg_wait got %b want %b", {clk_out, tick, busy}, {e_clk, e_tick, e_busy});
      end
      if (busy[1] !== 1'b1) break;
      checks++;
      if (cfg_ready !== 1'b0) begin errors++; $display("FAIL cfg_ready_pending got %b want 0", cfg_ready); end
      cycle();
    end
    checks++;
    if (busy[1] !== 1'b0) begin errors++; $display("FAIL busy_clear got %b want 0 (timeout)", busy[1]); end
    for (int j = 0; j < 8; j++) begin
      cycle();
      checks++;
      if (clk_out[1] !== 1'((j % 4) == 3) || tick[1] !== 1'((j % 4) == 0)) begin
        errors++; $display("FAIL cfg_pattern j=%0d got clk=%b tick=%b want clk=%b tick=%b",
                           j, clk_out[1], tick[1], (j % 4) == 3, (j % 4) == 0);
      end
      checks++;
      if ({clk_out, tick, busy} !== {e_clk, e_tick, e_busy}) begin
        errors++; $display("FAIL cfg_model got %b want %b", {clk_out, tick, busy}, {e_clk, e_tick, e_busy});
      end
    end
  endtask

  task automatic test_clamp();
    bit ok;
    int hi;
    int tk;
    int divs[3]  = '{1, 1, 3};
    int highs[3] = '{1, 0, 7};
    int lens[3]  = '{10, 10, 9};
    int whi[3]   = '{5, 0, 9};
    int wtk[3]   = '{5, 5, 3};
    for (int k = 0; k < 3; k++) begin
      write_and_apply(0, divs[k], highs[k], ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL clamp_apply case=%0d got busy=%b want 0", k, busy[0]); end
      hi = 0; tk = 0;
      for (int i = 0; i < lens[k]; i++) begin
        cycle();
        checks++;
        if ({clk_out, tick, busy} !== {e_clk, e_tick, e_busy}) begin
          errors++; $display("FAIL clamp_model case=%0d got %b want %b", k, {clk_out, tick, busy}, {e_clk, e_tick, e_busy});
        end
        if (clk_out[0] === 1'b1) hi++;
        if (tick[0] === 1'b1) tk++;
      end
      checks++;
      if (hi != whi[k] || tk != wtk[k]) begin
        errors++; $display("FAIL clamp_counts case=%0d got high=%0d ticks=%0d want %0d %0d", k, hi, tk, whi[k], wtk[k]);
      end
    end
  endtask

  task automatic test_en_gap();
    bit ok;
    write_and_apply(0, 100, 50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL gap_apply got busy=%b want 0", busy[0]); end
    repeat (30) cycle();
    en[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++;
      if (clk_out[0] !== 1'b0 || tick[0] !== 1'b0) begin
        errors++; $display("FAIL gap_low i=%0d got clk=%b tick=%b want 0 0", i, clk_out[0], tick[0]);
      end
    end
    en[0] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cycle();
      checks++;
      if (clk_out[0] !== 1'(i >= 50) || tick[0] !== 1'(i == 0)) begin
        errors++; $display("FAIL regap_wave i=%0d got clk=%b tick=%b want %b %b", i, clk_out[0], tick[0], i >= 50, i == 0);
      end
    end
  endtask

  task automatic test_random();
    int b;
    en = 2'b11;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        b = $urandom_range(0, CH - 1);
        en[b] = ~en[b];
      end
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_ch    = 1'($urandom_range(0, CH - 1));
      cfg_div   = CW'($urandom_range(0, 12));
      cfg_high  = CW'($urandom_range(0, 14));
      #1;
      checks++;
      if (cfg_ready !== 1'(!m_pend[cfg_ch])) begin
        errors++; $display("FAIL rand_ready i=%0d got %b want %b", i, cfg_ready, !m_pend[cfg_ch]);
      end
      cycle();
      checks++;
      if ({clk_out, tick, busy} !== {e_clk, e_tick, e_busy}) begin
        errors++; $display("FAIL rand_model i=%0d got %b want %b", i, {clk_out, tick, busy}, {e_clk, e_tick, e_busy});
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    bit ok;
    int hi0;
    int hi1;
    int tk1;
    en = 2'b11;
    write_and_apply(0, 3, 7, ok);
    write_and_apply(1, 6, 3, ok);
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_div = CW'(10); cfg_high = CW'(5);
    cycle();
    cfg_valid = 1'b0;
    checks++;
    if ({clk_out, tick, busy} !== {e_clk, e_tick, e_busy}) begin
      errors++; $display("FAIL areset_pre got %b want %b", {clk_out, tick, busy}, {e_clk, e_tick, e_busy});
    end
    #3 rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({clk_out, tick, busy} !== 6'b0) begin
      errors++; $display("FAIL areset_immediate got %b want 000000", {clk_out, tick, busy});
    end
    cycle(); cycle();
    rst = 1'b1;
    hi0 = 0; hi1 = 0; tk1 = 0;
    for (int i = 0; i < 200; i++) begin
      cycle();
      checks++;
      if ({clk_out, tick, busy} !== {e_clk, e_tick, e_busy}) begin
        errors++; $display("FAIL areset_model i=%0d got %b want %b", i, {clk_out, tick, busy}, {e_clk, e_tick, e_busy});
      end
      if (clk_out[0] === 1'b1) hi0++;
      if (clk_out[1] === 1'b1) hi1++;
      if (tick[1] === 1'b1) tk1++;
    end
    checks++;
    if (hi0 != 100 || hi1 != 100 || tk1 != 2) begin
      errors++; $display("FAIL areset_defaults got hi0=%0d hi1=%0d tk1=%0d want 100 100 2", hi0, hi1, tk1);
    end
  endtask

`ifdef CLKGEN_SYNC_EN
  task automatic test_sync();
    bit ok;
    int r;
    write_and_apply(0, 10, 5, ok);
    write_and_apply(1, 6, 3, ok);
    r = $urandom_range(1, 5);
    repeat (r) cycle();
    sync_n = 1'b0;
    cycle();
    sync_n = 1'b1;
    checks++;
    if (tick !== 2'b11) begin errors++; $display("FAIL sync_align got %b want 11", tick); end
    for (int i = 0; i < 60; i++) begin
      cycle();
      checks++;
      if ({clk_out, tick, busy} !== {e_clk, e_tick, e_busy}) begin
        errors++; $display("FAIL sync_model i=%0d got %b want %b", i, {clk_out, tick, busy}, {e_clk, e_tick, e_busy});
      end
      if (i == 29 || i == 59) begin
        checks++;
        if (tick !== 2'b11) begin errors++; $display("FAIL sync_realign i=%0d got %b want 11", i, tick); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_default_wave();
    test_cfg_busy();
    test_clamp();
    test_en_gap();
    test_random();
    test_async_reset();
`ifdef CLKGEN_SYNC_EN
    test_sync();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
